frv_gpr_writeback: RTL and testbench
====================================

# frv_gpr_writeback

Writeback stage that owns the write port of the general purpose register file (`frv_gprs`). It accepts completed instruction results from the pipeline with a valid/ready handshake. ALU results are written directly. For loads, the block waits for the data-memory response, aligns and sign-extends the data, then writes it. It also drives a pending-load scoreboard that decode uses for RAW hazard stalls.

## Interface
Parameters:
- none.

Ports:
- `g_clk` in 1: clock.
- `g_resetn` in 1: one clock; reset is asynchronous and active-low.
- `s_valid` in 1: result valid from previous stage.
- `s_ready` out 1: block can accept a result.
- `s_src` in 2: result source; `WB_SRC_ALU`=0, `WB_SRC_LOAD`=1, `WB_SRC_NONE`=2 (no write); 3 behaves as NONE.
- `s_rd` in 5: destination register.
- `s_wide` in 1: 64-bit result to register pair; ALU source only.
- `s_wdata` in 32: result [31:0].
- `s_wdata_hi` in 32: result [63:32].
- `s_ld_size` in 2: `LD_BYTE`=0, `LD_HALF`=1, `LD_WORD`=2.
- `s_ld_signed` in 1: sign-extend load data.
- `s_ld_off` in 2: byte offset of the load address.
- `dmem_rsp_valid` in 1: load response strobe.
- `dmem_rsp_rdata` in 32: raw word read.
- `dmem_rsp_error` in 1: bus error for the response.
- `rd_wen` out 1: GPR write enable.
- `rd_wide` out 1: GPR wide write.
- `rd_addr` out 5: GPR write address.
- `rd_wdata` out 32: GPR write data low.
- `rd_wdata_hi` out 32: GPR write data high.
- `gpr_pending` out 32: bit n set means a load to xn is outstanding.
- `wb_load_err` out 1: one-cycle pulse when a load response has an error.

## Operation
- States: `IDLE`, `WAIT_LOAD`.
- `s_ready` = (state == `IDLE`). A transfer happens when `s_valid && s_ready`.
- IDLE, accept with ALU source:
  - Registers `rd_wen`=1 and `rd_addr`=`s_rd`.
  - `rd_wdata`=`s_wdata`, `rd_wdata_hi`=`s_wdata_hi`, `rd_wide`=`s_wide`.
  - Stays in IDLE.
- IDLE, accept with LOAD source:
  - Latches rd, size, signed and offset.
  - Sets `gpr_pending[s_rd]` unless rd=0.
  - Moves to WAIT_LOAD.
  - `s_wide` is ignored.
- IDLE, accept with NONE source: no write, stays in IDLE.
- WAIT_LOAD, `dmem_rsp_valid` with no error:
  - Next cycle: `rd_wen`=1, `rd_wide`=0, `rd_wdata` = aligned data.
  - Clears the pending bit and returns to IDLE.
- WAIT_LOAD, `dmem_rsp_valid` with error:
  - No write; `wb_load_err` pulses next cycle.
  - Clears the pending bit and returns to IDLE.
- Load alignment:
  - Byte: `rdata[8*off +: 8]`.
  - Half: `rdata[16*off[1] +: 16]`; `off[0]` is ignored.
  - Word: offset ignored.
  - Extension is zero, or sign when `s_ld_signed`.
  - Misalignment is checked upstream.
- x0 rule:
  - A non-wide write with rd=0 gives `rd_wen`=0.
  - Wide writes force `rd_addr[0]`=0. x0 in a wide pair keeps `rd_wen`=1, and the register file discards the low half.
- `gpr_pending[0]` is always 0. At most one pending bit is set at any time.
- `dmem_rsp_valid` in IDLE is ignored.
- A response in the same cycle as the load accept is ignored; the earliest legal response is the cycle after accept.

## Timing
- Outputs are registered. The write occurs 1 cycle after an ALU accept, and 1 cycle after the load response.
- `rd_wen` and `wb_load_err` are single-cycle pulses; back-to-back ALU accepts give `rd_wen` high on consecutive cycles.
- `s_ready` falls in the cycle after a load accept. It rises in the cycle after the response, which is the same cycle `rd_wen` shows the load write.
- `gpr_pending` bit: set in the cycle after accept, cleared in the cycle after the response.
- Reset (asynchronous, any time including WAIT_LOAD):
  - state=IDLE.
  - `rd_wen`=0, `rd_wide`=0, `rd_addr`=0, `rd_wdata`=0, `rd_wdata_hi`=0.
  - `gpr_pending`=0, `wb_load_err`=0.
  - A response arriving after reset is ignored.

## Structure
- Shared package `frv_pkg`:
  - `WB_SRC_*` and `LD_*` encodings.
  - Width constants: `XLEN`=32, `REG_ADDR_W`=5.
- Sub-module `frv_load_align`: combinational byte/half/word extract and extend, taking (rdata, size, off, signed) and producing 32-bit data.
- FSM, output registers and scoreboard sit in the top module.

## Test plan
- ALU, rd=5, data 0xDEADBEEF → next cycle `rd_wen`=1, `rd_addr`=5, `rd_wdata`=0xDEADBEEF, `rd_wide`=0.
- Wide ALU, rd=7, lo 0x11111111, hi 0x22222222 → `rd_addr`=6, `rd_wide`=1, lo/hi as given.
- LB signed, off=3, rd=10, response after 4 cycles with rdata 0x80FF0102:
  - `s_ready`=0 and `gpr_pending`=0x400 while waiting.
  - Then `rd_wdata`=0xFFFFFF80 and pending clears.
- LHU, off=2, rdata 0x9ABC1234 → 0x00009ABC. Error response → no `rd_wen`, `wb_load_err` pulse, pending clears.
- ALU rd=0 → `rd_wen` stays 0. Reset asserted in WAIT_LOAD, then a late response → all outputs 0 and no write.

Source files
------------

// File: rtl/frv_pkg.sv
// Shared encodings and width constants for the frv pipeline slice.
package frv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [1:0] WB_SRC_ALU  = 2'd0;
    localparam logic [1:0] WB_SRC_LOAD = 2'd1;
    localparam logic [1:0] WB_SRC_NONE = 2'd2;

    localparam logic [1:0] LD_BYTE = 2'd0;
    localparam logic [1:0] LD_HALF = 2'd1;
    localparam logic [1:0] LD_WORD = 2'd2;

    // One-hot scoreboard mask for a destination register; x0 never pends.
    function automatic logic [XLEN-1:0] pending_mask(input logic [REG_ADDR_W-1:0] rd);
        logic [XLEN-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        m[0]  = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/frv_load_align.sv
// Combinational load data extract (byte/half/word) with zero or sign extension.
module frv_load_align
    import frv_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      size,
    input  logic [1:0]      off,
    input  logic            is_signed,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (off)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = off[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            LD_BYTE: data = {{24{is_signed & byte_v[7]}}, byte_v};
            LD_HALF: data = {{16{is_signed & half_v[15]}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/frv_gpr_writeback.sv
// Writeback stage: owns the GPR write port, completes loads and tracks the pending load.
module frv_gpr_writeback
    import frv_pkg::*;
(
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [1:0]            s_src,
    input  logic [REG_ADDR_W-1:0] s_rd,
    input  logic                  s_wide,
    input  logic [XLEN-1:0]       s_wdata,
    input  logic [XLEN-1:0]       s_wdata_hi,
    input  logic [1:0]            s_ld_size,
    input  logic                  s_ld_signed,
    input  logic [1:0]            s_ld_off,
    input  logic                  dmem_rsp_valid,
    input  logic [XLEN-1:0]       dmem_rsp_rdata,
    input  logic                  dmem_rsp_error,
    output logic                  rd_wen,
    output logic                  rd_wide,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd_wdata,
    output logic [XLEN-1:0]       rd_wdata_hi,
    output logic [XLEN-1:0]       gpr_pending,
    output logic                  wb_load_err
);

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_WAIT_LOAD = 1'b1;

    logic [0:0]            state;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [1:0]            ld_size;
    logic                  ld_signed;
    logic [1:0]            ld_off;
    logic [XLEN-1:0]       ld_data;
    logic                  accept;

    assign s_ready = (state == ST_IDLE);
    assign accept  = s_valid && s_ready;

    frv_load_align u_load_align (
        .rdata     (dmem_rsp_rdata),
        .size      (ld_size),
        .off       (ld_off),
        .is_signed (ld_signed),
        .data      (ld_data)
    );

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state       <= ST_IDLE;
            ld_rd       <= '0;
            ld_size     <= '0;
            ld_signed   <= 1'b0;
            ld_off      <= '0;
            rd_wen      <= 1'b0;
            rd_wide     <= 1'b0;
            rd_addr     <= '0;
            rd_wdata    <= '0;
            rd_wdata_hi <= '0;
            gpr_pending <= '0;
            wb_load_err <= 1'b0;
        end else begin
            rd_wen      <= 1'b0;
            wb_load_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && s_src == WB_SRC_ALU) begin
                        // Wide pairs always write (x0 low half is dropped by the regfile).
                        rd_wen      <= s_wide || (s_rd != '0);
                        rd_wide     <= s_wide;
                        rd_addr     <= s_wide ? {s_rd[REG_ADDR_W-1:1], 1'b0} : s_rd;
                        rd_wdata    <= s_wdata;
                        rd_wdata_hi <= s_wdata_hi;
                    end else if (accept && s_src == WB_SRC_LOAD) begin
                        ld_rd       <= s_rd;
                        ld_size     <= s_ld_size;
                        ld_signed   <= s_ld_signed;
                        ld_off      <= s_ld_off;
                        gpr_pending <= pending_mask(s_rd);
                        state       <= ST_WAIT_LOAD;
                    end
                end
                ST_WAIT_LOAD: begin
                    if (dmem_rsp_valid) begin
                        if (dmem_rsp_error) begin
                            wb_load_err <= 1'b1;
                        end else begin
                            rd_wen   <= (ld_rd != '0);
                            rd_wide  <= 1'b0;
                            rd_addr  <= ld_rd;
                            rd_wdata <= ld_data;
                        end
                        gpr_pending <= '0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frv_gpr_writeback.sv
// Randomized self-checking bench for frv_gpr_writeback against a transaction-level model.
module tb_frv_gpr_writeback;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_src;
    logic [4:0]  s_rd;
    logic        s_wide;
    logic [31:0] s_wdata;
    logic [31:0] s_wdata_hi;
    logic [1:0]  s_ld_size;
    logic        s_ld_signed;
    logic [1:0]  s_ld_off;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        dmem_rsp_error;
    logic        rd_wen;
    logic        rd_wide;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] rd_wdata_hi;
    logic [31:0] gpr_pending;
    logic        wb_load_err;

    always #5 g_clk = ~g_clk;

    frv_gpr_writeback dut (
        .g_clk          (g_clk),
        .g_resetn       (g_resetn),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_src          (s_src),
        .s_rd           (s_rd),
        .s_wide         (s_wide),
        .s_wdata        (s_wdata),
        .s_wdata_hi     (s_wdata_hi),
        .s_ld_size      (s_ld_size),
        .s_ld_signed    (s_ld_signed),
        .s_ld_off       (s_ld_off),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata),
        .dmem_rsp_error (dmem_rsp_error),
        .rd_wen         (rd_wen),
        .rd_wide        (rd_wide),
        .rd_addr        (rd_addr),
        .rd_wdata       (rd_wdata),
        .rd_wdata_hi    (rd_wdata_hi),
        .gpr_pending    (gpr_pending),
        .wb_load_err    (wb_load_err)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Model state: is a load outstanding, and what was latched for it.
    bit          m_wait;
    logic [4:0]  m_rd;
    logic [1:0]  m_size;
    logic        m_signed;
    logic [1:0]  m_off;
    logic [31:0] m_pending;

    function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [1:0] size,
                                             input logic [1:0] off, input logic sgn);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (raw >> (8 * int'(off))) & 32'hFF;
            if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (raw >> ((off >= 2'd2) ? 16 : 0)) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = raw;
        end
        return v;
    endfunction

    task automatic drive(input logic v, input logic [1:0] src, input logic [4:0] rd, input logic wide,
                         input logic [31:0] lo, input logic [31:0] hi, input logic [1:0] size,
                         input logic sgn, input logic [1:0] off, input logic rsp,
                         input logic [31:0] rdata, input logic err);
        s_valid = v; s_src = src; s_rd = rd; s_wide = wide; s_wdata = lo; s_wdata_hi = hi;
        s_ld_size = size; s_ld_signed = sgn; s_ld_off = off;
        dmem_rsp_valid = rsp; dmem_rsp_rdata = rdata; dmem_rsp_error = err;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 2'd2, 5'd0, 1'b0, '0, '0, 2'd0, 1'b0, 2'd0, 1'b0, '0, 1'b0);
    endtask

    // Called just after a falling edge with inputs applied; returns after the next falling edge.
    task automatic step();
        logic        e_wen, e_err, e_wide, e_chk_hi;
        logic [4:0]  e_addr;
        logic [31:0] e_lo, e_hi;
        e_wen = 0; e_err = 0; e_wide = 0; e_chk_hi = 0; e_addr = '0; e_lo = '0; e_hi = '0;

        check_eq("s_ready", 32'(s_ready), 32'(!m_wait));
        if (!m_wait) begin
            if (s_valid && s_src == 2'd0) begin
                e_wen    = s_wide || (s_rd != 0);
                e_wide   = s_wide;
                e_addr   = s_wide ? (s_rd & 5'h1E) : s_rd;
                e_lo     = s_wdata;
                e_hi     = s_wdata_hi;
                e_chk_hi = 1;
            end else if (s_valid && s_src == 2'd1) begin
                m_wait    = 1;
                m_rd      = s_rd;
                m_size    = s_ld_size;
                m_signed  = s_ld_signed;
                m_off     = s_ld_off;
                m_pending = (s_rd == 0) ? 32'h0 : (32'h1 << s_rd);
            end
        end else if (dmem_rsp_valid) begin
            if (dmem_rsp_error) begin
                e_err = 1;
            end else begin
                e_wen  = (m_rd != 0);
                e_addr = m_rd;
                e_lo   = ref_load(dmem_rsp_rdata, m_size, m_off, m_signed);
            end
            m_wait    = 0;
            m_pending = 0;
        end

        @(posedge g_clk);
        #1;
        check_eq("rd_wen", 32'(rd_wen), 32'(e_wen));
        check_eq("wb_load_err", 32'(wb_load_err), 32'(e_err));
        check_eq("gpr_pending", gpr_pending, m_pending);
        if (e_wen) begin
            check_eq("rd_addr", 32'(rd_addr), 32'(e_addr));
            check_eq("rd_wide", 32'(rd_wide), 32'(e_wide));
            check_eq("rd_wdata", rd_wdata, e_lo);
            if (e_chk_hi) check_eq("rd_wdata_hi", rd_wdata_hi, e_hi);
        end
        @(negedge g_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_wen"}, 32'(rd_wen), 32'd0);
        check_eq({tag, "_wide"}, 32'(rd_wide), 32'd0);
        check_eq({tag, "_addr"}, 32'(rd_addr), 32'd0);
        check_eq({tag, "_wdata"}, rd_wdata, 32'd0);
        check_eq({tag, "_wdata_hi"}, rd_wdata_hi, 32'd0);
        check_eq({tag, "_pending"}, gpr_pending, 32'd0);
        check_eq({tag, "_err"}, 32'(wb_load_err), 32'd0);
        check_eq({tag, "_ready"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        m_wait = 0; m_rd = '0; m_size = '0; m_signed = 0; m_off = '0; m_pending = '0;
        idle_inputs();
        g_resetn = 1'b0;
        repeat (3) @(negedge g_clk);
        check_all_zero("reset");
        g_resetn = 1'b1;

        // ALU rd=5
        drive(1, 2'd0, 5'd5, 0, 32'hDEADBEEF, 32'h0, 2'd0, 0, 2'd0, 0, '0, 0);
        step();
        check_eq("t_alu_addr", 32'(rd_addr), 32'd5);
        check_eq("t_alu_data", rd_wdata, 32'hDEADBEEF);

        // Wide ALU rd=7 -> pair x6/x7
        drive(1, 2'd0, 5'd7, 1, 32'h11111111, 32'h22222222, 2'd0, 0, 2'd0, 0, '0, 0);
        step();
        check_eq("t_wide_addr", 32'(rd_addr), 32'd6);
        check_eq("t_wide_hi", rd_wdata_hi, 32'h22222222);

        // LB signed off=3 rd=10, held-off ALU offers while waiting
        drive(1, 2'd1, 5'd10, 1, '0, '0, 2'd0, 1, 2'd3, 1, 32'h12345678, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'd0, 5'd3, 0, 32'h5555AAAA, '0, 2'd0, 0, 2'd0, 0, '0, 0);
            check_eq("t_lb_wait_ready", 32'(s_ready), 32'd0);
            check_eq("t_lb_wait_pend", gpr_pending, 32'h400);
            step();
        end
        drive(0, 2'd0, 5'd0, 0, '0, '0, 2'd0, 0, 2'd0, 1, 32'h80FF0102, 0);
        step();
        check_eq("t_lb_data", rd_wdata, 32'hFFFFFF80);
        check_eq("t_lb_pend", gpr_pending, 32'h0);
        check_eq("t_lb_ready", 32'(s_ready), 32'd1);

        // LHU off=2
        drive(1, 2'd1, 5'd9, 0, '0, '0, 2'd1, 0, 2'd2, 0, '0, 0);
        step();
        drive(0, 2'd0, 5'd0, 0, '0, '0, 2'd0, 0, 2'd0, 1, 32'h9ABC1234, 0);
        step();
        check_eq("t_lhu_data", rd_wdata, 32'h00009ABC);

        // Load with bus error
        drive(1, 2'd1, 5'd4, 0, '0, '0, 2'd2, 0, 2'd0, 0, '0, 0);
        step();
        drive(0, 2'd0, 5'd0, 0, '0, '0, 2'd0, 0, 2'd0, 1, 32'hFFFFFFFF, 1);
        step();
        check_eq("t_err_pulse", 32'(wb_load_err), 32'd1);
        check_eq("t_err_wen", 32'(rd_wen), 32'd0);

        // ALU to x0
        drive(1, 2'd0, 5'd0, 0, 32'h12345678, '0, 2'd0, 0, 2'd0, 0, '0, 0);
        step();
        check_eq("t_x0_wen", 32'(rd_wen), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  1'($urandom_range(0, 1)), $urandom, $urandom,
                  2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 3) == 0));
            step();
        end

        // Reset while a load is outstanding, then a late response
        drive(1, 2'd1, 5'd12, 0, '0, '0, 2'd2, 0, 2'd0, 0, '0, 0);
        step();
        idle_inputs();
        drive(1, 2'd0, 5'd8, 0, 32'hCAFEF00D, 32'h1, 2'd0, 0, 2'd0, 0, '0, 0);
        check_eq("t_rst_pre_pend", gpr_pending, 32'h1000);
        #1;
        g_resetn = 1'b0;
        #1;
        check_all_zero("t_async_rst");
        g_resetn = 1'b1;
        m_wait = 0; m_pending = '0;
        drive(0, 2'd0, 5'd0, 0, '0, '0, 2'd2, 0, 2'd0, 1, 32'hA5A5A5A5, 0);
        step();
        check_all_zero("t_late_rsp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
